adjust_sequencer: RTL

//  Front-panel controller for the digital clock datapath. It debounces the four

---
 rtl/adjust_sequencer_pkg.sv | 37 +++
 rtl/adjust_sequencer_key_debounce.sv | 51 +++++
 rtl/adjust_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/adjust_sequencer_pkg.sv
// Shared definitions for the digital clock front panel: field codes, FSM states,
// key event bundle and a counter-width helper.
package adjust_sequencer_pkg;

    localparam int unsigned NUM_FIELDS = 7;
    localparam int unsigned FLD_W      = 4;
    localparam int unsigned NUM_KEYS   = 4;
    localparam int unsigned KEY_ADD    = 0;

    typedef enum logic [FLD_W-1:0] {
        FLD_SEC    = 4'd0,
        FLD_MIN    = 4'd1,
        FLD_HOUR   = 4'd2,
        FLD_DAY    = 4'd3,
        FLD_MONTH  = 4'd4,
        FLD_YEAR_L = 4'd5,
        FLD_YEAR_H = 4'd6
    } field_e;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ADJ = 1'b1
    } state_e;

    // Bit order matches KEY: [3]=clr [2]=mode [1]=next [0]=add
    typedef struct packed {
        logic clr;
        logic mode;
        logic next;
        logic add;
    } key_evt_t;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adjust_sequencer_key_debounce.sv
// One push button: 2-FF synchroniser, debounce filter and a one-cycle press pulse
// on the debounced released->pressed transition.
module adjust_sequencer_key_debounce
    import adjust_sequencer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press
);

    localparam int unsigned CW = cnt_w(DEBOUNCE_CYC);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          w_in;
    logic          w_flip;

    // Synchronised level is kept in pressed-high polarity
    assign w_in   = r_sync[1];
    assign w_flip = (w_in != r_level) && (r_cnt == CW'(DEBOUNCE_CYC - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], ~i_key_n};
            r_press <= w_flip && !r_level;
            if ((w_in == r_level) || w_flip) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_flip) begin
                r_level <= w_in;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/adjust_sequencer.sv
// Front-panel controller: debounced keys drive a RUN/ADJUST FSM that selects the
// field being edited and issues add/clr commands, add auto-repeat and blink.
module adjust_sequencer
    import adjust_sequencer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned HOLD_CYC     = 25_000_000,
    parameter int unsigned REPEAT_CYC   = 5_000_000,
    parameter int unsigned TIMEOUT_CYC  = 500_000_000,
    parameter int unsigned BLINK_CYC    = 12_500_000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [3:0]       KEY,
    output logic             adjust,
    output logic [FLD_W-1:0] select,
    output logic             add,
    output logic             clr,
    output logic             blink
);

    localparam int unsigned HMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int unsigned HW   = cnt_w(HMAX);
    localparam int unsigned TW   = cnt_w(TIMEOUT_CYC);
    localparam int unsigned BW   = cnt_w(BLINK_CYC);

    logic [NUM_KEYS-1:0] w_level;
    logic [NUM_KEYS-1:0] w_press;
    key_evt_t            w_evt;
    logic                w_unused_levels;

    state_e              r_state;
    logic                r_adjust;
    logic [FLD_W-1:0]    r_select;
    logic                r_add;
    logic                r_clr;
    logic                r_blink;
    logic                r_hold_arm;
    logic                r_rep_phase;
    logic [HW-1:0]       r_hold_cnt;
    logic [TW-1:0]       r_tcnt;
    logic [BW-1:0]       r_bcnt;

    logic [HW-1:0]       w_rep_lim;
    logic                w_rep_fire;
    logic                w_timeout;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        adjust_sequencer_key_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_key_debounce (
            .i_clk   (CLOCK_50),
            .i_reset (reset),
            .i_key_n (KEY[g]),
            .o_level (w_level[g]),
            .o_press (w_press[g])
        );
    end

    // Only the add key's held level matters here
    assign w_unused_levels = ^w_level[NUM_KEYS-1:1];
    assign w_evt           = key_evt_t'(w_press);

    // First repeat waits HOLD_CYC from the press event, later ones REPEAT_CYC apart
    assign w_rep_lim  = r_rep_phase ? HW'(REPEAT_CYC - 1) : HW'(HOLD_CYC - 1);
    assign w_rep_fire = r_hold_arm && w_level[KEY_ADD] && (r_hold_cnt == w_rep_lim);
    assign w_timeout  = !(|w_press) && !w_rep_fire && (r_tcnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_adjust    <= 1'b0;
            r_select    <= FLD_SEC;
            r_add       <= 1'b0;
            r_clr       <= 1'b0;
            r_blink     <= 1'b0;
            r_hold_arm  <= 1'b0;
            r_rep_phase <= 1'b0;
            r_hold_cnt  <= '0;
            r_tcnt      <= '0;
            r_bcnt      <= '0;
        end else begin
            r_add <= 1'b0;
            r_clr <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    r_hold_arm <= 1'b0;
                    if (w_evt.mode) begin
                        r_state  <= ST_ADJ;
                        r_adjust <= 1'b1;
                        r_select <= FLD_SEC;
                        r_blink  <= 1'b1;
                        r_bcnt   <= '0;
                        r_tcnt   <= '0;
                    end
                end
                ST_ADJ: begin
                    if (r_bcnt == BW'(BLINK_CYC - 1)) begin
                        r_bcnt  <= '0;
                        r_blink <= ~r_blink;
                    end else begin
                        r_bcnt <= r_bcnt + BW'(1);
                    end
                    r_tcnt <= r_tcnt + TW'(1);

                    if (r_hold_arm) begin
                        if (!w_level[KEY_ADD]) begin
                            r_hold_arm <= 1'b0;
                        end else if (w_rep_fire) begin
                            r_hold_cnt  <= '0;
                            r_rep_phase <= 1'b1;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + HW'(1);
                        end
                    end

                    // Event priority mode > next > clr > add; any of them beats a repeat pulse
                    if (w_evt.mode || w_timeout) begin
                        r_state    <= ST_RUN;
                        r_adjust   <= 1'b0;
                        r_select   <= FLD_SEC;
                        r_blink    <= 1'b0;
                        r_hold_arm <= 1'b0;
                    end else if (w_evt.next) begin
                        r_select   <= (r_select == FLD_YEAR_H) ? FLD_SEC : r_select + FLD_W'(1);
                        r_blink    <= 1'b1;
                        r_bcnt     <= '0;
                        r_tcnt     <= '0;
                        r_hold_arm <= 1'b0;
                    end else if (w_evt.clr) begin
                        r_clr      <= 1'b1;
                        r_tcnt     <= '0;
                        r_hold_arm <= 1'b0;
                    end else if (w_evt.add) begin
                        r_add       <= 1'b1;
                        r_tcnt      <= '0;
                        r_hold_arm  <= 1'b1;
                        r_rep_phase <= 1'b0;
                        r_hold_cnt  <= '0;
                    end else if (w_rep_fire) begin
                        r_add  <= 1'b1;
                        r_tcnt <= '0;
                    end
                end
            endcase
        end
    end

    assign adjust = r_adjust;
    assign select = r_select;
    assign add    = r_add;
    assign clr    = r_clr;
    assign blink  = r_blink;

endmodule
